// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
//   Shared types and default widths for the frame sequencer and its readout
//   sub-module.
//   frame_state_t : per-frame controller state
//   FS_ADDR_W     : default object index width (matches city m10k_address_len)
//   FS_COUNT_W    : width of the completed-frame counter
package frame_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_DRAIN   = 3'd4
   } frame_state_t;

   localparam int FS_ADDR_W  = 12;
   localparam int FS_COUNT_W = 16;

endpackage

// File: rtl/frame_seq_readout.sv
// frame_seq_readout
//   DRAIN-phase engine: walks the city acceleration memory from index 0 to
//   num-1, waits READ_LAT cycles after each address change, captures the data
//   into a holding register and presents it on a valid/ready stream. The next
//   address is issued as soon as a capture happens, so with acc_ready held
//   high one result leaves every READ_LAT+1 cycles.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         one-cycle pulse: begin a drain of num results
//   abort         drop any drain in progress
//   num           object count N (>= 1 when start is pulsed)
//   accel_addr    city acceleration read index
//   x_accel/y_accel city read data
//   acc_valid/acc_ready, acc_index, acc_x, acc_y  result stream
//   last          strobe: handshake of the final result happens this cycle
module frame_seq_readout
   import frame_seq_pkg::*;
#(
   parameter int ADDR_W   = FS_ADDR_W,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num,
   output logic [ADDR_W-1:0] accel_addr,
   input  logic [31:0]       x_accel,
   input  logic [31:0]       y_accel,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ADDR_W-1:0] acc_index,
   output logic [31:0]       acc_x,
   output logic [31:0]       acc_y,
   output logic              last
);

   localparam int LAT_W = $clog2(READ_LAT + 2);

   logic [ADDR_W-1:0] rd_idx;
   logic [LAT_W-1:0]  lat;
   logic              fetching;
   logic [ADDR_W:0]   last_idx;
   logic              hs;
   logic              capture;
   logic              last_fetch;

   assign last_idx   = num - 1'b1;
   assign hs         = acc_valid && acc_ready;
   assign last       = hs && ({1'b0, acc_index} == last_idx);
   assign last_fetch = ({1'b0, rd_idx} == last_idx);
   // Read data is trusted only once the address has been stable READ_LAT
   // cycles, and only moves into the holding register when it is free or
   // emptying this very cycle.
   assign capture    = fetching && (lat == LAT_W'(READ_LAT)) && (!acc_valid || acc_ready);
   assign accel_addr = rd_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_idx    <= '0;
         lat       <= '0;
         fetching  <= 1'b0;
         acc_valid <= 1'b0;
         acc_index <= '0;
         acc_x     <= '0;
         acc_y     <= '0;
      end else if (abort) begin
         rd_idx    <= '0;
         lat       <= '0;
         fetching  <= 1'b0;
         acc_valid <= 1'b0;
      end else if (start) begin
         rd_idx    <= '0;
         lat       <= '0;
         fetching  <= 1'b1;
         acc_valid <= 1'b0;
      end else begin
         if (capture) begin
            acc_x     <= x_accel;
            acc_y     <= y_accel;
            acc_index <= rd_idx;
            acc_valid <= 1'b1;
            lat       <= '0;
            if (last_fetch)
               fetching <= 1'b0;
            else
               rd_idx <= rd_idx + 1'b1;
         end else begin
            if (hs)
               acc_valid <= 1'b0;
            if (fetching && (lat != LAT_W'(READ_LAT)))
               lat <= lat + 1'b1;
         end
         // Park the read address at 0 once the frame is fully drained.
         if (last)
            rd_idx <= '0;
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Per-frame controller between the HPS bridge and the city gravity solver:
//   CLEAR resets city, LOAD streams N object records into it, COMPUTE runs it
//   until done, DRAIN streams the N accelerations back out.
//   Optional feature macro: FRAME_SEQ_TIMEOUT_EN adds a COMPUTE watchdog of
//   TIMEOUT cycles that flags error and returns to IDLE.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   host_start, host_abort      frame request / abort (abort wins)
//   host_num_objects            object count, latched on accepted start
//   load_valid/ready, load_*    object record stream in
//   city_*                      every city control / data input, plus done
//                               and acceleration read data from city
//   acc_valid/ready, acc_*      acceleration result stream out
//   busy, frame_done, error, frame_count  status
module frame_sequencer
   import frame_seq_pkg::*;
#(
   parameter int MAX_SIZE = 4096,
   parameter int ADDR_W   = FS_ADDR_W,
   parameter int READ_LAT = 2,
   parameter int TIMEOUT  = 1 << 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  host_start,
   input  logic                  host_abort,
   input  logic [ADDR_W:0]       host_num_objects,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [31:0]           load_x,
   input  logic [31:0]           load_y,
   input  logic [31:0]           load_mass,
   output logic                  city_reset,
   output logic                  city_sending,
   output logic [ADDR_W-1:0]     city_num_objects,
   output logic                  city_pos_we,
   output logic [ADDR_W-1:0]     city_pos_write_addr,
   output logic [31:0]           city_x,
   output logic [31:0]           city_y,
   output logic [31:0]           city_mass,
   input  logic                  city_done,
   output logic [ADDR_W-1:0]     city_accel_addr,
   input  logic [31:0]           city_x_accel,
   input  logic [31:0]           city_y_accel,
   output logic                  acc_valid,
   input  logic                  acc_ready,
   output logic [ADDR_W-1:0]     acc_index,
   output logic [31:0]           acc_x,
   output logic [31:0]           acc_y,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  error,
   output logic [FS_COUNT_W-1:0] frame_count
);

   localparam int NW = ADDR_W + 1;
   localparam logic [NW-1:0] MAX_N = NW'(MAX_SIZE);

   frame_state_t  state, state_nxt;
   logic [NW-1:0] n_q;
   logic [NW-1:0] load_cnt;
   logic          comp_armed;
   logic          rd_start, rd_last;
   logic          accept, zero_req, over_req, to_hit, frame_end;

`ifdef FRAME_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (reset || (state != ST_COMPUTE))
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   assign to_hit = (state == ST_COMPUTE) && (to_cnt == TO_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_start  = 1'b0;
      accept    = 1'b0;
      zero_req  = 1'b0;
      over_req  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (host_start && !host_abort) begin
               if (host_num_objects == '0) begin
                  zero_req = 1'b1;
               end else if (host_num_objects > MAX_N) begin
                  over_req = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = ST_CLEAR;
               end
            end
         end
         ST_CLEAR: state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (load_valid && (load_cnt == n_q - 1'b1))
               state_nxt = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            // comp_armed is low on the first COMPUTE cycle, hiding a done
            // left over from before city was reset.
            if (comp_armed && city_done) begin
               state_nxt = ST_DRAIN;
               rd_start  = 1'b1;
            end else if (to_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (rd_last)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (host_abort) begin
         state_nxt = ST_IDLE;
         rd_start  = 1'b0;
      end
   end

   assign frame_end = zero_req || ((state == ST_DRAIN) && rd_last && !host_abort);

   always_ff @(posedge clk) begin
      if (reset) begin
         n_q         <= '0;
         load_cnt    <= '0;
         comp_armed  <= 1'b0;
         frame_done  <= 1'b0;
         error       <= 1'b0;
         frame_count <= '0;
      end else begin
         comp_armed <= (state == ST_COMPUTE);
         frame_done <= frame_end;
         if (frame_end)
            frame_count <= frame_count + 1'b1;
         if (accept) begin
            n_q   <= host_num_objects;
            error <= 1'b0;
         end else if (over_req || (to_hit && !host_abort)) begin
            error <= 1'b1;
         end
         if (state != ST_LOAD)
            load_cnt <= '0;
         else if (load_valid)
            load_cnt <= load_cnt + 1'b1;
      end
   end

   frame_seq_readout #(
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT)
   ) u_readout (
      .clk        (clk),
      .reset      (reset),
      .start      (rd_start),
      .abort      (host_abort),
      .num        (n_q),
      .accel_addr (city_accel_addr),
      .x_accel    (city_x_accel),
      .y_accel    (city_y_accel),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_index  (acc_index),
      .acc_x      (acc_x),
      .acc_y      (acc_y),
      .last       (rd_last)
   );

   assign busy                = (state != ST_IDLE);
   assign load_ready          = (state == ST_LOAD);
   // city is held in reset everywhere except while it computes or is read.
   assign city_reset          = (state != ST_COMPUTE) && (state != ST_DRAIN);
   assign city_sending        = (state == ST_COMPUTE);
   // A count of exactly 2^ADDR_W has no representation on this port and
   // appears as 0; city is expected to treat it as full.
   assign city_num_objects    = (state == ST_IDLE) ? '0 : n_q[ADDR_W-1:0];
   assign city_pos_we         = load_ready && load_valid;
   assign city_pos_write_addr = load_ready ? load_cnt[ADDR_W-1:0] : '0;
   assign city_x              = city_pos_we ? load_x    : '0;
   assign city_y              = city_pos_we ? load_y    : '0;
   assign city_mass           = city_pos_we ? load_mass : '0;

endmodule

// File: tb/tb_frame_sequencer.sv
`timescale 1ns/1ps
module tb_frame_sequencer;

   localparam int MAX_SIZE = 4096;
   localparam int ADDR_W   = 12;
   localparam int READ_LAT = 2;
   localparam int TIMEOUT  = 50;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic              host_start = 1'b0, host_abort = 1'b0;
   logic [ADDR_W:0]   host_num_objects = '0;
   logic              load_valid = 1'b0, load_ready;
   logic [31:0]       load_x = '0, load_y = '0, load_mass = '0;
   logic              city_reset, city_sending, city_pos_we, city_done;
   logic [ADDR_W-1:0] city_num_objects, city_pos_write_addr, city_accel_addr;
   logic [31:0]       city_x, city_y, city_mass, city_x_accel, city_y_accel;
   logic              acc_valid, acc_ready = 1'b0;
   logic [ADDR_W-1:0] acc_index;
   logic [31:0]       acc_x, acc_y;
   logic              busy, frame_done, error;
   logic [15:0]       frame_count;

   int checks = 0;
   int errors = 0;
   int exp_fc = 0;

   // Stub city: done a programmable number of cycles into sending, x accel
   // = index + 100 + per-frame offset, y accel = the y written to that index,
   // both seen READ_LAT (=2) cycles after the read address.
   int                done_delay = 1000;
   logic              done_force = 1'b0;
   int                send_cnt = 0;
   logic [31:0]       xoff = '0;
   logic [31:0]       mem_y [0:MAX_SIZE-1];
   logic [ADDR_W-1:0] a_p1 = '0, a_p2 = '0;

   always @(posedge clk) begin
      if (city_reset) send_cnt <= 0;
      else if (city_sending) send_cnt <= send_cnt + 1;
      if (city_pos_we) mem_y[city_pos_write_addr] <= city_y;
      a_p1 <= city_accel_addr;
      a_p2 <= a_p1;
   end
   assign city_done    = done_force || (send_cnt >= done_delay);
   assign city_x_accel = 32'(a_p2) + 32'd100 + xoff;
   assign city_y_accel = mem_y[a_p2];

   frame_sequencer #(
      .MAX_SIZE(MAX_SIZE), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .host_start(host_start), .host_abort(host_abort),
      .host_num_objects(host_num_objects), .load_valid(load_valid), .load_ready(load_ready),
      .load_x(load_x), .load_y(load_y), .load_mass(load_mass),
      .city_reset(city_reset), .city_sending(city_sending), .city_num_objects(city_num_objects),
      .city_pos_we(city_pos_we), .city_pos_write_addr(city_pos_write_addr),
      .city_x(city_x), .city_y(city_y), .city_mass(city_mass), .city_done(city_done),
      .city_accel_addr(city_accel_addr), .city_x_accel(city_x_accel), .city_y_accel(city_y_accel),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_index(acc_index),
      .acc_x(acc_x), .acc_y(acc_y), .busy(busy), .frame_done(frame_done),
      .error(error), .frame_count(frame_count)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({busy, load_ready, city_reset, city_sending, city_pos_we, acc_valid, frame_done, error} !== 8'b0010_0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 00100000",
                  {busy, load_ready, city_reset, city_sending, city_pos_we, acc_valid, frame_done, error});
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++; $display("FAIL reset_count: got %0d required 0", frame_count);
      end
      checks++;
      if ({city_num_objects, city_pos_write_addr, city_accel_addr, acc_index} !== 48'd0) begin
         errors++; $display("FAIL reset_addr: got %h required 0",
                            {city_num_objects, city_pos_write_addr, city_accel_addr, acc_index});
      end
      checks++;
      if ({city_x, city_y, city_mass, acc_x, acc_y} !== 160'd0) begin
         errors++; $display("FAIL reset_data: got nonzero %h required 0", {city_x, city_y, city_mass, acc_x, acc_y});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Runs one full frame of n objects. gap_pct: chance a cycle has no record,
   // rdy_pct: chance acc_ready is high, ddly: cycles into COMPUTE that the
   // stub raises done, stale: done already high before COMPUTE.
   task automatic run_frame(input string name, input int n, input int gap_pct,
                            input int rdy_pct, input int ddly, input bit stale);
      logic [31:0]       rx [64];
      logic [31:0]       ry [64];
      logic [31:0]       rm [64];
      int                nw, nr, cyc, first_comp, first_drain, last_hs;
      bit                expect_fd, finished, stall;
      logic [ADDR_W-1:0] s_idx;
      logic [31:0]       s_x, s_y;
      for (int i = 0; i < n; i++) begin
         rx[i] = $urandom; ry[i] = $urandom; rm[i] = $urandom;
      end
      xoff       = $urandom;
      done_delay = ddly;
      @(negedge clk);
      host_start = 1'b1; host_num_objects = 13'(n); done_force = stale;
      @(negedge clk);
      host_start = 1'b0;
      #1;
      checks++;
      if ({busy, city_reset, load_ready, error} !== 4'b1100) begin
         errors++; $display("FAIL %s clear_state: got busy/rst/rdy/err=%b required 1100",
                            name, {busy, city_reset, load_ready, error});
      end
      checks++;
      if (city_num_objects !== 12'(n)) begin
         errors++; $display("FAIL %s num_objects: got %0d required %0d", name, city_num_objects, n);
      end
      nw = 0; nr = 0; cyc = 2; first_comp = -1; first_drain = -1; last_hs = -1;
      expect_fd = 0; finished = 0; stall = 0;
      s_idx = '0; s_x = '0; s_y = '0;
      while (!finished && cyc < 3000) begin
         @(negedge clk);
         if (first_comp >= 0) done_force = 1'b0;
         load_valid = (nw < n) && ($urandom_range(99) >= gap_pct);
         if (nw < n) begin
            load_x = rx[nw]; load_y = ry[nw]; load_mass = rm[nw];
         end
         acc_ready = ($urandom_range(99) < rdy_pct);
         #1;
         if (expect_fd) begin
            checks++;
            if (frame_done !== 1'b1 || busy !== 1'b0 || frame_count !== 16'(exp_fc + 1)) begin
               errors++; $display("FAIL %s frame_end: got fd=%b busy=%b count=%0d required 1 0 %0d",
                                  name, frame_done, busy, frame_count, exp_fc + 1);
            end
            exp_fc++;
            finished = 1;
         end else begin
            checks++;
            if (frame_done !== 1'b0) begin
               errors++; $display("FAIL %s early_done: got frame_done=%b required 0 at cycle %0d", name, frame_done, cyc);
            end
            if (load_valid && load_ready) begin
               checks++;
               if ({city_pos_we, city_pos_write_addr, city_x, city_y, city_mass} !==
                   {1'b1, 12'(nw), rx[nw], ry[nw], rm[nw]}) begin
                  errors++; $display("FAIL %s load_write: got we=%b addr=%0d x=%h required we=1 addr=%0d x=%h",
                                     name, city_pos_we, city_pos_write_addr, city_x, nw, rx[nw]);
               end
               nw++;
            end else begin
               checks++;
               if (city_pos_we !== 1'b0) begin
                  errors++; $display("FAIL %s stray_write: got we=%b required 0", name, city_pos_we);
               end
            end
            if (city_sending === 1'b1 && first_comp < 0) begin
               first_comp = cyc;
               checks++;
               if (nw != n) begin
                  errors++; $display("FAIL %s compute_entry: got %0d writes required %0d", name, nw, n);
               end
               if (gap_pct == 0) begin
                  checks++;
                  if (cyc != 2 + n) begin
                     errors++; $display("FAIL %s compute_cycle: got t+%0d required t+%0d", name, cyc, 2 + n);
                  end
               end
            end
            if (stale && first_comp >= 0 && cyc == first_comp + 1) begin
               checks++;
               if (city_sending !== 1'b1) begin
                  errors++; $display("FAIL %s stale_done: got sending=%b required 1", name, city_sending);
               end
            end
            if (first_comp >= 0 && first_drain < 0 && city_sending === 1'b0) begin
               first_drain = cyc;
               checks++;
               if (cyc != first_comp + ddly + 1) begin
                  errors++; $display("FAIL %s drain_entry: got cycle %0d required %0d", name, cyc, first_comp + ddly + 1);
               end
            end
            if (stall) begin
               checks++;
               if (acc_valid !== 1'b1 || acc_index !== s_idx || acc_x !== s_x || acc_y !== s_y) begin
                  errors++; $display("FAIL %s acc_stable: got v=%b idx=%0d x=%h required v=1 idx=%0d x=%h",
                                     name, acc_valid, acc_index, acc_x, s_idx, s_x);
               end
            end
            stall = 0;
            if (acc_valid === 1'b1) begin
               checks++;
               if (nr >= n) begin
                  errors++; $display("FAIL %s acc_extra: got idx=%0d required no result", name, acc_index);
               end else if (acc_index !== 12'(nr) || acc_x !== 32'(nr) + 32'd100 + xoff || acc_y !== ry[nr]) begin
                  errors++; $display("FAIL %s acc_data: got idx=%0d x=%h y=%h required idx=%0d x=%h y=%h",
                                     name, acc_index, acc_x, acc_y, nr, 32'(nr) + 32'd100 + xoff, ry[nr]);
               end
               if (acc_ready) begin
                  if (rdy_pct == 100 && nr > 0) begin
                     checks++;
                     if (cyc - last_hs != READ_LAT + 1) begin
                        errors++; $display("FAIL %s drain_rate: got %0d cycles required %0d", name, cyc - last_hs, READ_LAT + 1);
                     end
                  end
                  last_hs = cyc;
                  nr++;
                  if (nr == n) expect_fd = 1;
               end else begin
                  stall = 1; s_idx = acc_index; s_x = acc_x; s_y = acc_y;
               end
            end
         end
         cyc++;
      end
      if (!finished) begin
         checks++; errors++;
         $display("FAIL %s frame_timeout: got %0d results required %0d", name, nr, n);
      end
      @(negedge clk);
      load_valid = 1'b0; acc_ready = 1'b0;
      #1;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || city_num_objects !== 12'd0) begin
         errors++; $display("FAIL %s post_frame: got fd=%b busy=%b num=%0d required 0 0 0",
                            name, frame_done, busy, city_num_objects);
      end
   endtask

   task automatic test_basic();
      run_frame("basic", 4, 0, 100, 10, 1'b0);
   endtask

   task automatic test_zero_objects();
      @(negedge clk);
      host_start = 1'b1; host_num_objects = '0;
      #1;
      checks++;
      if (busy !== 1'b0 || city_pos_we !== 1'b0) begin
         errors++; $display("FAIL zero_start: got busy=%b we=%b required 0 0", busy, city_pos_we);
      end
      @(negedge clk);
      host_start = 1'b0;
      #1;
      checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0 || frame_count !== 16'(exp_fc + 1)) begin
         errors++; $display("FAIL zero_done: got fd=%b busy=%b count=%0d required 1 0 %0d",
                            frame_done, busy, frame_count, exp_fc + 1);
      end
      exp_fc++;
      @(negedge clk);
      #1;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_after: got fd=%b busy=%b required 0 0", frame_done, busy);
      end
   endtask

   task automatic test_oversize();
      @(negedge clk);
      host_start = 1'b1; host_num_objects = 13'(MAX_SIZE + 1);
      @(negedge clk);
      host_start = 1'b0;
      #1;
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'(exp_fc)) begin
         errors++; $display("FAIL oversize: got err=%b busy=%b fd=%b count=%0d required 1 0 0 %0d",
                            error, busy, frame_done, frame_count, exp_fc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (error !== 1'b1) begin
         errors++; $display("FAIL error_sticky: got %b required 1", error);
      end
      // N = MAX_SIZE is the largest legal count: it must be accepted.
      @(negedge clk);
      host_start = 1'b1; host_num_objects = 13'(MAX_SIZE);
      @(negedge clk);
      host_start = 1'b0; host_abort = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1 || error !== 1'b0) begin
         errors++; $display("FAIL max_accept: got busy=%b err=%b required 1 0", busy, error);
      end
      @(negedge clk);
      host_abort = 1'b0;
      // Leave error set again so the next frame shows it being cleared.
      host_start = 1'b1; host_num_objects = 13'(MAX_SIZE + 1);
      @(negedge clk);
      host_start = 1'b0;
      run_frame("clear_error", 1, 0, 100, 3, 1'b0);
   endtask

   task automatic test_backpressure();
      run_frame("backpressure", 12, 40, 50, 6, 1'b0);
      for (int k = 0; k < 3; k++)
         run_frame("random", int'($urandom_range(1, 20)), 30, 60, int'($urandom_range(1, 15)), 1'b0);
   endtask

   task automatic test_abort();
      @(negedge clk);
      host_start = 1'b1; host_num_objects = 13'd5;
      @(negedge clk);
      host_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         load_valid = 1'b1; load_x = $urandom; load_y = $urandom; load_mass = $urandom;
         #1;
         checks++;
         if (city_pos_we !== 1'b1 || city_pos_write_addr !== 12'(i)) begin
            errors++; $display("FAIL abort_load: got we=%b addr=%0d required 1 %0d", city_pos_we, city_pos_write_addr, i);
         end
      end
      @(negedge clk);
      load_valid = 1'b0; host_abort = 1'b1; host_start = 1'b1;
      @(negedge clk);
      host_abort = 1'b0; host_start = 1'b0;
      #1;
      checks++;
      if ({busy, city_reset, load_ready, frame_done, city_sending} !== 5'b01000 || frame_count !== 16'(exp_fc)) begin
         errors++; $display("FAIL abort_idle: got busy/rst/rdy/fd/send=%b count=%0d required 01000 %0d",
                            {busy, city_reset, load_ready, frame_done, city_sending}, frame_count, exp_fc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_after: got fd=%b busy=%b required 0 0", frame_done, busy);
      end
      run_frame("after_abort", 3, 0, 100, 4, 1'b0);
   endtask

   task automatic test_stale_done();
      run_frame("stale_done", 3, 0, 100, 5, 1'b1);
   endtask

   task automatic test_timeout();
`ifdef FRAME_SEQ_TIMEOUT_EN
      int ncomp;
      done_delay = 100000;
      @(negedge clk);
      host_start = 1'b1; host_num_objects = 13'd1;
      @(negedge clk);
      host_start = 1'b0;
      @(negedge clk);
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      ncomp = (city_sending === 1'b1) ? 1 : 0;
      while (ncomp > 0 && ncomp < 200) begin
         @(negedge clk);
         #1;
         if (city_sending === 1'b1) ncomp++;
         else break;
      end
      checks++;
      if (ncomp != TIMEOUT || busy !== 1'b0 || error !== 1'b1 || frame_done !== 1'b0) begin
         errors++; $display("FAIL timeout: got %0d cycles busy=%b err=%b fd=%b required %0d 0 1 0",
                            ncomp, busy, error, frame_done, TIMEOUT);
      end
      run_frame("after_timeout", 2, 0, 100, 3, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_objects();
      test_oversize();
      test_backpressure();
      test_abort();
      test_stale_done();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame controller that sits between the HPS bridge and the `city` gravity solver. Each frame it clears the solver, streams object records into `city` with a valid/ready handshake, runs the computation until `city` reports done, then drains per-object accelerations out as a valid/ready stream. It owns every `city` control input (`reset`, `sending`, `num_objects`, write port, acceleration read address), so the HPS never drives the solver directly.

## Interface
Parameters:
- MAX_SIZE, 4096, maximum object count; must match `city`
- ADDR_W, 12, object index width; must match `city` m10k_address_len
- READ_LAT, 2, cycles from `city_accel_addr` change to valid `city_x_accel`/`city_y_accel`
- TIMEOUT, 2^24, COMPUTE watchdog limit in cycles (only with FRAME_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- host_start  in  1  start-frame request; sampled only in IDLE
- host_abort  in  1  return to IDLE from any state
- host_num_objects  in  ADDR_W+1  object count; latched on an accepted start
- load_valid / load_ready  in / out  1  object-record handshake
- load_x, load_y, load_mass  in  32 each  object record
- city_reset  out  1  drives `city` reset
- city_sending  out  1  drives `city` sending
- city_num_objects  out  ADDR_W  latched count
- city_pos_we  out  1  `city` write enable
- city_pos_write_addr  out  ADDR_W  `city` write index
- city_x, city_y, city_mass  out  32 each  `city` write data
- city_done  in  1  `city` done
- city_accel_addr  out  ADDR_W  `city` acceleration read index
- city_x_accel, city_y_accel  in  32 each  `city` read data
- acc_valid / acc_ready  out / in  1  result handshake
- acc_index  out  ADDR_W  index of the presented result
- acc_x, acc_y  out  32 each  result data
- busy  out  1  high when the state is not IDLE
- frame_done  out  1  one-cycle pulse at frame end
- error  out  1  sticky; cleared by the next accepted start
- frame_count  out  16  completed frames; wraps at 2^16

## Operation
- States: IDLE, CLEAR, LOAD, COMPUTE, DRAIN.
- **IDLE, on host_start:**
  - If host_num_objects = 0: pulse frame_done, increment frame_count, stay in IDLE.
  - If host_num_objects > MAX_SIZE: set error, stay in IDLE.
  - Otherwise: latch the count into N, clear error, go to CLEAR.
- **CLEAR:** city_reset = 1 for exactly 1 cycle, then go to LOAD.
- **LOAD:**
  - city_reset stays 1 and load_ready = 1.
  - On each load_valid & load_ready: city_pos_we = 1 for that cycle, with city_pos_write_addr = load counter and data passed through combinationally. The counter then increments.
  - After N writes, go to COMPUTE.
- **COMPUTE:**
  - city_reset = 0 and city_sending = 1.
  - city_done is ignored on the first COMPUTE cycle, which masks a stale done from before the reset.
  - city_done = 1 on any later cycle goes to DRAIN.
- **DRAIN:** for i = 0 .. N-1:
  - Drive city_accel_addr = i and wait READ_LAT cycles.
  - Register the data and index, then assert acc_valid and hold it until acc_ready.
  - After the handshake on index N-1: pulse frame_done, increment frame_count, go to IDLE.
- **host_abort in any state:** go to IDLE next cycle, drive city_reset = 1 on that cycle, no frame_done, frame_count unchanged. host_abort takes priority over host_start in the same cycle.
- **city_num_objects:** holds N from CLEAR onward and is 0 in IDLE.

## Timing
- **Reset values:** state IDLE, busy 0, load_ready 0, city_reset 1, city_sending 0, city_pos_we 0, acc_valid 0, frame_done 0, error 0, frame_count 0. All address and data outputs are 0.
- **Start to CLEAR:** host_start sampled in cycle t puts the block in CLEAR at t+1; LOAD opens at t+2.
- **Load throughput:** 1 record per cycle. With N records back-to-back, the first COMPUTE cycle is t+2+N.
- **Drain throughput:** 1 result per READ_LAT+1 cycles when acc_ready is held high.
- **acc_* stability:** acc_x, acc_y and acc_index stay stable while acc_valid & !acc_ready.
- **frame_done:** asserted in the same cycle as the final acc handshake's registered update, i.e. the cycle after that handshake; busy falls in that same cycle.

## Configuration
- **With FRAME_SEQ_TIMEOUT_EN defined:** a cycle counter runs in COMPUTE. When it reaches TIMEOUT without city_done, the block sets error, pulses city_reset, and returns to IDLE with no frame_done.
- **Without it:** COMPUTE waits indefinitely and the TIMEOUT parameter is unused.

## Structure
- **Package `frame_seq_pkg`:** state enum `frame_state_t` and the default widths (ADDR_W, frame_count width).
- **Sub-module `frame_seq_readout`:** the DRAIN read-latency counter plus the output holding register with the acc handshake. It is started by the top FSM and returns a last-handshake strobe.

## Test plan
- **Basic frame:** N=4, records streamed back-to-back, stub city asserts done 10 cycles into COMPUTE with accel[i] = i+100 → 4 writes to addresses 0..3, acc_index 0..3 with acc_x = 100..103, one frame_done, frame_count = 1.
- **Zero objects:** start with N=0 → frame_done pulse the next cycle, busy never 1, no city_pos_we.
- **Oversize count:** start with N = MAX_SIZE+1 → error = 1, state stays IDLE. A following start with N=1 clears error.
- **Backpressure:** acc_ready toggling 1010…, and load_valid gaps → no lost or duplicated results, acc_* stable while stalled.
- **Abort:** abort in LOAD after 2 of 5 writes → IDLE next cycle, city_reset = 1, frame_count unchanged. A new frame then runs correctly.
- **Stale done and timeout:** city_done held high into COMPUTE → the first cycle is ignored. With FRAME_SEQ_TIMEOUT_EN and TIMEOUT = 50 and no done → error after 50 cycles, return to IDLE.
